// File: rtl/fetch_unit_pkg.sv
// Shared widths, fetch step, 32-bit address mask and front-end state encoding
// for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int ADDR_W = 64;
  localparam int INSTR_W = 32;
  localparam int FETCH_STEP = 4;
  localparam logic [63:0] ADDR_MASK_32 = 64'h0000_0000_FFFF_FFFF;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with flush and a combinational head read.
// Overflow protection is the caller's job; the fetch credit rule guarantees it.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clock) begin
    if (push && !reset && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign empty     = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues in-order word fetches
// under a credit limit, buffers responses and handles branch redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int addressWidth = ADDR_W,
  parameter int instructionWidth = INSTR_W,
  parameter int fifoDepth = 4,
  parameter logic [addressWidth-1:0] resetVector = '0
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        is64Bit_i,
  input  logic                        isBranching_i,
  input  logic [addressWidth-1:0]     branchTarget_i,
  output logic                        memReq_o,
  output logic [addressWidth-1:0]     memAddr_o,
  input  logic                        memReady_i,
  input  logic                        memValid_i,
  input  logic [instructionWidth-1:0] memData_i,
  input  logic                        stall_i,
  output logic                        instrValid_o,
  output logic [instructionWidth-1:0] instruction_o,
  output logic [addressWidth-1:0]     instructionAddress_o
);

  localparam int CW = $clog2(fifoDepth) + 1;
  localparam logic [addressWidth-1:0] LOW_MASK = addressWidth'(ADDR_MASK_32);
  localparam logic [addressWidth-1:0] STEP = addressWidth'(FETCH_STEP);

  function automatic logic [addressWidth-1:0] mask_addr(input logic [addressWidth-1:0] a,
                                                        input logic wide);
    return wide ? a : (a & LOW_MASK);
  endfunction

  fetch_state_t state, state_next;
  logic [addressWidth-1:0] fetch_pc, resp_pc, latched_target, target_masked, load_pc;
  logic [CW-1:0] outstanding, outstanding_next, fifo_count;
  logic req, fire, push, pop, fifo_empty, head_valid, load_target;
  logic [addressWidth+instructionWidth-1:0] head_data;

  assign target_masked    = mask_addr(branchTarget_i, is64Bit_i);
  assign fire             = req && memReady_i;
  assign outstanding_next = outstanding + CW'(fire) - CW'(memValid_i);
  assign push             = memValid_i && (state == RUN) && !isBranching_i;
  assign head_valid       = !fifo_empty && !reset_i;
  assign pop              = head_valid && !stall_i && !isBranching_i;

  always_ff @(posedge clock_i) begin
    if (reset_i) state <= RUN;
    else         state <= state_next;
  end

  // A redirect with nothing left in flight restarts immediately; otherwise drain first.
  always_comb begin
    state_next  = state;
    load_target = 1'b0;
    load_pc     = latched_target;
    case (state)
      RUN: begin
        if (isBranching_i) begin
          if (outstanding_next == '0) begin
            load_target = 1'b1;
            load_pc     = target_masked;
          end else begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!isBranching_i && outstanding_next == '0) begin
          state_next  = RUN;
          load_target = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Requests are capped so that in-flight plus buffered words always fit the FIFO.
  always_comb begin
    req = 1'b0;
    if (state == RUN)
      req = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(fifoDepth);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fetch_pc       <= resetVector;
      resp_pc        <= resetVector;
      latched_target <= resetVector;
      outstanding    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (isBranching_i) latched_target <= target_masked;
      if (load_target) begin
        fetch_pc <= load_pc;
        resp_pc  <= load_pc;
      end else begin
        if (fire) fetch_pc <= mask_addr(fetch_pc + STEP, is64Bit_i);
        if (push) resp_pc  <= mask_addr(resp_pc + STEP, is64Bit_i);
      end
    end
  end

  fetch_fifo #(
    .DEPTH(fifoDepth),
    .WIDTH(addressWidth + instructionWidth)
  ) u_fifo (
    .clock     (clock_i),
    .reset     (reset_i),
    .flush     (isBranching_i),
    .push      (push),
    .push_data ({resp_pc, memData_i}),
    .pop       (pop),
    .head_data (head_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign memReq_o             = req && !reset_i;
  assign memAddr_o            = fetch_pc;
  assign instrValid_o         = head_valid;
  assign instruction_o        = head_valid ? head_data[instructionWidth-1:0] : '0;
  assign instructionAddress_o = head_valid ? head_data[addressWidth+instructionWidth-1:instructionWidth] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit: per-cycle stimulus rows with
// hand-computed expectations plus a credit-limit sequence with a 1-cycle memory.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        is64_bit = 1'b1;
  logic        is_branching = 1'b0;
  logic [63:0] branch_target = '0;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_data = '0;
  logic        stall = 1'b0;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [63:0] instruction_address;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  fetch_unit dut (
    .clock_i              (clock),
    .reset_i              (reset),
    .is64Bit_i            (is64_bit),
    .isBranching_i        (is_branching),
    .branchTarget_i       (branch_target),
    .memReq_o             (mem_req),
    .memAddr_o            (mem_addr),
    .memReady_i           (mem_ready),
    .memValid_i           (mem_valid),
    .memData_i            (mem_data),
    .stall_i              (stall),
    .instrValid_o         (instr_valid),
    .instruction_o        (instruction),
    .instructionAddress_o (instruction_address)
  );

  typedef struct {
    logic        rst;
    logic        br;
    logic [63:0] tgt;
    logic        is64;
    logic        rdy;
    logic        vld;
    logic [31:0] data;
    logic        stl;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_valid;
    logic [63:0] e_iaddr;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic br, input logic [63:0] tgt,
                              input logic is64, input logic rdy, input logic vld,
                              input logic [31:0] data, input logic stl, input logic e_req,
                              input logic [63:0] e_addr, input logic e_valid,
                              input logic [63:0] e_iaddr, input logic [31:0] e_instr);
    vec_t v;
    v.rst = rst; v.br = br; v.tgt = tgt; v.is64 = is64; v.rdy = rdy; v.vld = vld;
    v.data = data; v.stl = stl; v.e_req = e_req; v.e_addr = e_addr;
    v.e_valid = e_valid; v.e_iaddr = e_iaddr; v.e_instr = e_instr;
    return v;
  endfunction

  function automatic logic [31:0] word_for(input logic [63:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Holds reset across two edges, then checks the reset output values.
  task automatic doReset(input logic is64);
    @(negedge clock);
    reset = 1'b1; is64_bit = is64; is_branching = 1'b0; branch_target = '0;
    mem_ready = 1'b0; mem_valid = 1'b0; mem_data = '0; stall = 1'b0;
    @(negedge clock);
    #1;
    checkOutput("reset_mem_req", {63'd0, mem_req}, 64'd0);
    checkOutput("reset_mem_addr", mem_addr, 64'd0);
    checkOutput("reset_instr_valid", {63'd0, instr_valid}, 64'd0);
    checkOutput("reset_instruction", {32'd0, instruction}, 64'd0);
    checkOutput("reset_instr_addr", instruction_address, 64'd0);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    if (v.rst) doReset(v.is64);
    @(negedge clock);
    reset = 1'b0; is64_bit = v.is64; is_branching = v.br; branch_target = v.tgt;
    mem_ready = v.rdy; mem_valid = v.vld; mem_data = v.vld ? v.data : 32'd0; stall = v.stl;
    #1;
    checkOutput($sformatf("row%0d_mem_req", idx), {63'd0, mem_req}, {63'd0, v.e_req});
    if (v.e_req) checkOutput($sformatf("row%0d_mem_addr", idx), mem_addr, v.e_addr);
    checkOutput($sformatf("row%0d_instr_valid", idx), {63'd0, instr_valid}, {63'd0, v.e_valid});
    if (v.e_valid) begin
      checkOutput($sformatf("row%0d_instr_addr", idx), instruction_address, v.e_iaddr);
      checkOutput($sformatf("row%0d_instruction", idx), {32'd0, instruction}, {32'd0, v.e_instr});
    end
  endtask

  initial begin
    // Back-to-back fetch with a single-cycle memory; decoder never stalls.
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0,             0, 1, 64'h0,  0, 0,     0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 32'hC0DE_0000, 0, 1, 64'h4,  0, 0,     0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 32'hC0DE_0004, 0, 1, 64'h8,  1, 64'h0, 32'hC0DE_0000));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 32'hC0DE_0008, 0, 1, 64'hC,  1, 64'h4, 32'hC0DE_0004));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 32'hC0DE_000C, 0, 1, 64'h10, 1, 64'h8, 32'hC0DE_0008));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,             0, 1, 64'h10, 1, 64'hC, 32'hC0DE_000C));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,             0, 1, 64'h10, 0, 0,     0));
    // memReady low for three cycles while 0x8 is presented.
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0,             0, 1, 64'h0,  0, 0,     0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 32'hC0DE_0000, 0, 1, 64'h4,  0, 0,     0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 32'hC0DE_0004, 0, 1, 64'h8,  1, 64'h0, 32'hC0DE_0000));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,             0, 1, 64'h8,  1, 64'h4, 32'hC0DE_0004));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,             0, 1, 64'h8,  0, 0,     0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0,             0, 1, 64'h8,  0, 0,     0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 32'hC0DE_0008, 0, 1, 64'hC,  0, 0,     0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,             0, 1, 64'hC,  1, 64'h8, 32'hC0DE_0008));
    // Redirect with two requests in flight: drain, drop both, restart at 0x100.
    vecs.push_back(mk(1, 0, 0,      1, 1, 0, 0,             0, 1, 64'h0,   0, 0,       0));
    vecs.push_back(mk(0, 0, 0,      1, 1, 0, 0,             0, 1, 64'h4,   0, 0,       0));
    vecs.push_back(mk(0, 1, 64'h100, 1, 0, 0, 0,             0, 1, 64'h8,   0, 0,       0));
    vecs.push_back(mk(0, 0, 0,      1, 1, 1, 32'hC0DE_0000, 0, 0, 0,       0, 0,       0));
    vecs.push_back(mk(0, 0, 0,      1, 1, 1, 32'hC0DE_0004, 0, 0, 0,       0, 0,       0));
    vecs.push_back(mk(0, 0, 0,      1, 1, 0, 0,             0, 1, 64'h100, 0, 0,       0));
    vecs.push_back(mk(0, 0, 0,      1, 0, 1, 32'hC0DE_0100, 0, 1, 64'h104, 0, 0,       0));
    vecs.push_back(mk(0, 0, 0,      1, 0, 0, 0,             0, 1, 64'h104, 1, 64'h100, 32'hC0DE_0100));
    // Redirect coinciding with a response and a pop; last in-flight word retires that cycle.
    vecs.push_back(mk(1, 0, 0,      1, 1, 0, 0,             0, 1, 64'h0,   0, 0,       0));
    vecs.push_back(mk(0, 0, 0,      1, 1, 1, 32'hC0DE_0000, 0, 1, 64'h4,   0, 0,       0));
    vecs.push_back(mk(0, 1, 64'h200, 1, 0, 1, 32'hC0DE_0004, 0, 1, 64'h8,   1, 64'h0,   32'hC0DE_0000));
    vecs.push_back(mk(0, 0, 0,      1, 1, 0, 0,             0, 1, 64'h200, 0, 0,       0));
    vecs.push_back(mk(0, 0, 0,      1, 0, 1, 32'hC0DE_0200, 0, 1, 64'h204, 0, 0,       0));
    vecs.push_back(mk(0, 0, 0,      1, 0, 0, 0,             0, 1, 64'h204, 1, 64'h200, 32'hC0DE_0200));
    // 32-bit mode: top-of-space target is masked, then the PC wraps to zero.
    vecs.push_back(mk(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 0, 1, 64'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,             0, 1, 64'h0000_0000_FFFF_FFFC, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hC0DE_FFFC, 0, 1, 64'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,             0, 1, 64'h0, 1, 64'h0000_0000_FFFF_FFFC, 32'hC0DE_FFFC));
    // 64-bit mode: the same target is kept intact and wraps modulo 2^64.
    vecs.push_back(mk(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 0, 0, 1, 64'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 64'h0, 0, 0, 0));
    // Redirect on a handshake cycle goes to DRAIN; a second redirect in DRAIN wins.
    vecs.push_back(mk(1, 0, 0,       1, 1, 0, 0,             0, 1, 64'h0,   0, 0, 0));
    vecs.push_back(mk(0, 1, 64'h100, 1, 1, 0, 0,             0, 1, 64'h4,   0, 0, 0));
    vecs.push_back(mk(0, 1, 64'h300, 1, 1, 1, 32'hC0DE_0000, 0, 0, 0,       0, 0, 0));
    vecs.push_back(mk(0, 0, 0,       1, 1, 1, 32'hC0DE_0004, 0, 0, 0,       0, 0, 0));
    vecs.push_back(mk(0, 0, 0,       1, 1, 0, 0,             0, 1, 64'h300, 0, 0, 0));

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Credit limit: decoder stalled, 1-cycle memory model answers every handshake.
    begin
      int          n_req = 0;
      logic        pend = 1'b0;
      logic [63:0] pend_addr = '0;
      logic [63:0] exp_addr = 64'h0;
      doReset(1'b1);
      for (int i = 0; i < 8; i++) begin
        @(negedge clock);
        reset = 1'b0; mem_ready = 1'b1; stall = 1'b1;
        mem_valid = pend; mem_data = pend ? word_for(pend_addr) : 32'd0;
        #1;
        if (mem_req) begin
          checkOutput($sformatf("credit_addr%0d", n_req), mem_addr, exp_addr);
          exp_addr = exp_addr + 64'd4;
          n_req++;
        end
        pend = mem_req && mem_ready;
        pend_addr = mem_addr;
      end
      checkOutput("credit_request_count", 64'(n_req), 64'd4);
      @(negedge clock);
      mem_valid = 1'b0; mem_data = '0; stall = 1'b0;
      #1;
      checkOutput("credit_full_no_req", {63'd0, mem_req}, 64'd0);
      checkOutput("credit_head_addr", instruction_address, 64'h0);
      @(negedge clock);
      stall = 1'b1; mem_ready = 1'b0;
      #1;
      checkOutput("credit_req_after_pop", {63'd0, mem_req}, 64'd1);
      checkOutput("credit_addr_after_pop", mem_addr, 64'h10);
      checkOutput("credit_next_head_addr", instruction_address, 64'h4);
      checkOutput("credit_next_head_data", {32'd0, instruction}, {32'd0, word_for(64'h4)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
